// File: rtl/fetch_if_id_stage_pkg.sv
//============================================================================
// Module      : riscv_pipe_pkg
// Description : Shared widths, bubble encoding and fetch FSM states for the
//               instruction-fetch stage and its IF/ID register.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

package riscv_pipe_pkg;

   localparam int XLEN = 32;

   // addi x0,x0,0 : what decode sees when IF/ID carries no instruction
   localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

   // FETCH : request outstanding at pc_q
   // HOLD  : instruction parked in the skid buffer during a stall
   // DRAIN : redirected while a request was in flight; waiting for its reply
   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_HOLD  = 2'd1,
      S_DRAIN = 2'd2
   } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_if_id_stage_if.sv
//============================================================================
// Module      : fetch_if_id_stage_if
// Description : Hazard/decode controls, instruction-memory handshake and
//               IF/ID outputs of the fetch stage, bundled as one interface.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

interface fetch_if_id_stage_if;

   logic                             stall_i;
   logic                             flush_i;
   logic [riscv_pipe_pkg::XLEN-1:0]  branch_target_i;
   logic                             imem_req_o;
   logic [riscv_pipe_pkg::XLEN-1:0]  imem_addr_o;
   logic                             imem_ready_i;
   logic [riscv_pipe_pkg::XLEN-1:0]  imem_inst_i;
   logic [riscv_pipe_pkg::XLEN-1:0]  inst_o;
   logic [riscv_pipe_pkg::XLEN-1:0]  pc_o;
   logic                             valid_o;

   // The fetch stage drives the memory request and the IF/ID outputs
   modport master (
      input  stall_i, flush_i, branch_target_i, imem_ready_i, imem_inst_i,
      output imem_req_o, imem_addr_o, inst_o, pc_o, valid_o
   );

   // Hazard unit, decode and instruction memory
   modport slave (
      output stall_i, flush_i, branch_target_i, imem_ready_i, imem_inst_i,
      input  imem_req_o, imem_addr_o, inst_o, pc_o, valid_o
   );

endinterface

`default_nettype wire

// File: rtl/fetch_if_id_stage_reg.sv
//============================================================================
// Module      : if_id_reg
// Description : 65-bit IF/ID pipeline register {inst, pc, valid} with
//               bubble > hold > load priority and asynchronous reset.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module if_id_reg #(
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        load,
   input  wire logic        hold,
   input  wire logic        bubble,
   input  wire logic [31:0] d_inst,
   input  wire logic [31:0] d_pc,
   output logic      [31:0] inst,
   output logic      [31:0] pc,
   output logic             valid
);

   // Bubble wins over hold, hold over load; with no control the contents persist
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst  <= NOP_INST;
         pc    <= 32'd0;
         valid <= 1'b0;
      end else if (bubble) begin
         inst  <= NOP_INST;
         pc    <= 32'd0;
         valid <= 1'b0;
      end else if (hold) begin
         inst  <= inst;
         pc    <= pc;
         valid <= valid;
      end else if (load) begin
         inst  <= d_inst;
         pc    <= d_pc;
         valid <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/fetch_if_id_stage.sv
//============================================================================
// Module      : fetch_if_id_stage
// Description : Program counter, single-outstanding fetch handshake, stall
//               skid buffer and redirect drain, feeding the IF/ID register.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module fetch_if_id_stage
   import riscv_pipe_pkg::fetch_state_t,
          riscv_pipe_pkg::S_FETCH,
          riscv_pipe_pkg::S_HOLD,
          riscv_pipe_pkg::S_DRAIN;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = riscv_pipe_pkg::NOP_INST
) (
   input  wire logic            clk_i,
   input  wire logic            rst_i,
   fetch_if_id_stage_if.master  bus
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d, pc_inc;
   logic [31:0]  buf_inst, buf_pc;
   logic         buf_we;
   logic         ifid_load, ifid_hold, ifid_bubble;
   logic [31:0]  ld_inst, ld_pc;

   assign pc_inc = pc_q + 32'd4;

   // Request is a level tied to FETCH, suppressed while reset is held
   assign bus.imem_req_o  = (state_q == S_FETCH) && !rst_i;
   assign bus.imem_addr_o = pc_q;

   // Next-state, PC and IF/ID control decode; flush beats stall beats normal flow
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      buf_we      = 1'b0;
      ifid_load   = 1'b0;
      ifid_hold   = 1'b0;
      ifid_bubble = 1'b0;
      ld_inst     = bus.imem_inst_i;
      ld_pc       = pc_q;
      case (state_q)
         S_FETCH: begin
            if (bus.flush_i) begin
               // A reply this cycle is simply dropped; without one the old
               // request is still in flight and must be drained first
               pc_d        = bus.branch_target_i;
               ifid_bubble = 1'b1;
               if (!bus.imem_ready_i) state_d = S_DRAIN;
            end else if (bus.stall_i) begin
               ifid_hold = 1'b1;
               if (bus.imem_ready_i) begin
                  buf_we  = 1'b1;
                  pc_d    = pc_inc;
                  state_d = S_HOLD;
               end
            end else if (bus.imem_ready_i) begin
               ifid_load = 1'b1;
               pc_d      = pc_inc;
            end else begin
               ifid_bubble = 1'b1;
            end
         end
         S_HOLD: begin
            if (bus.flush_i) begin
               pc_d        = bus.branch_target_i;
               ifid_bubble = 1'b1;
               state_d     = S_FETCH;
            end else if (bus.stall_i) begin
               ifid_hold = 1'b1;
            end else begin
               ifid_load = 1'b1;
               ld_inst   = buf_inst;
               ld_pc     = buf_pc;
               state_d   = S_FETCH;
            end
         end
         S_DRAIN: begin
            // The stale reply ends the drain whatever else happens this cycle
            if (bus.imem_ready_i) state_d = S_FETCH;
            if (bus.flush_i) begin
               pc_d        = bus.branch_target_i;
               ifid_bubble = 1'b1;
            end else if (bus.stall_i) begin
               ifid_hold = 1'b1;
            end else begin
               ifid_bubble = 1'b1;
            end
         end
         default: begin
            state_d     = S_FETCH;
            ifid_bubble = 1'b1;
         end
      endcase
   end

   // FSM state and program counter
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Skid buffer captures the instruction that returned during a stall
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         buf_inst <= NOP_INST;
         buf_pc   <= 32'd0;
      end else if (buf_we) begin
         buf_inst <= bus.imem_inst_i;
         buf_pc   <= pc_q;
      end
   end

   if_id_reg #(
      .NOP_INST (NOP_INST)
   ) u_if_id_reg (
      .clk    (clk_i),
      .rst    (rst_i),
      .load   (ifid_load),
      .hold   (ifid_hold),
      .bubble (ifid_bubble),
      .d_inst (ld_inst),
      .d_pc   (ld_pc),
      .inst   (bus.inst_o),
      .pc     (bus.pc_o),
      .valid  (bus.valid_o)
   );

endmodule

`default_nettype wire

// File: tb/tb_fetch_if_id_stage.sv
//============================================================================
// Module      : tb_fetch_if_id_stage
// Description : Directed vector table, reset-mid-wait sequence and random
//               traffic against a fetch-stream reference model.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_if_id_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic        stall;
      logic        flush;
      logic        ready;
      logic [31:0] tgt;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic [31:0] exp_pc;
      logic [31:0] exp_inst;
      logic        exp_valid;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   vec_t vecs[$];

   // Reference model: fetch PC, whether an unanswered request is stale,
   // whether a parked instruction exists, and the IF/ID contents
   logic [31:0] m_pc;
   logic        m_stale;
   logic        m_parked;
   logic [31:0] m_buf_inst, m_buf_pc;
   logic [31:0] m_inst, m_out_pc;
   logic        m_valid;

   fetch_if_id_stage_if bus ();

   fetch_if_id_stage #(
      .RESET_PC (32'h0000_0000),
      .NOP_INST (NOP)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic s, input logic f, input logic r, input logic [31:0] t,
                      input logic rq, input logic [31:0] a, input logic [31:0] p,
                      input logic [31:0] i, input logic v);
      vec_t e;
      e.stall = s; e.flush = f; e.ready = r; e.tgt = t;
      e.exp_req = rq; e.exp_addr = a; e.exp_pc = p; e.exp_inst = i; e.exp_valid = v;
      vecs.push_back(e);
   endtask

   // Memory returns 0x100+addr for live requests, junk otherwise
   task automatic drive(input logic s, input logic f, input logic r, input logic [31:0] t);
      bus.stall_i         = s;
      bus.flush_i         = f;
      bus.imem_ready_i    = r;
      bus.branch_target_i = t;
      bus.imem_inst_i     = bus.imem_req_o ? (bus.imem_addr_o + 32'h100) : $urandom;
   endtask

   task automatic check_all(input string tag, input logic rq, input logic [31:0] a,
                            input logic [31:0] p, input logic [31:0] i, input logic v);
      chk({tag, ".req"},   {31'd0, bus.imem_req_o}, {31'd0, rq});
      chk({tag, ".addr"},  bus.imem_addr_o, a);
      chk({tag, ".pc"},    bus.pc_o, p);
      chk({tag, ".inst"},  bus.inst_o, i);
      chk({tag, ".valid"}, {31'd0, bus.valid_o}, {31'd0, v});
   endtask

   // Advance the model one edge from the spec's rules on outstanding work
   task automatic model_step(input logic s, input logic f, input logic r,
                             input logic [31:0] t, input logic [31:0] ii);
      logic live_req;
      live_req = !m_parked && !m_stale;
      if (f) begin
         m_stale  = (live_req || m_stale) && !r;
         m_parked = 1'b0;
         m_pc     = t;
         m_inst = NOP; m_out_pc = 0; m_valid = 0;
      end else if (s) begin
         if (live_req && r) begin
            m_parked = 1'b1; m_buf_inst = ii; m_buf_pc = m_pc; m_pc = m_pc + 4;
         end
         if (m_stale && r) m_stale = 1'b0;
      end else begin
         if (m_parked) begin
            m_inst = m_buf_inst; m_out_pc = m_buf_pc; m_valid = 1; m_parked = 1'b0;
         end else if (live_req && r) begin
            m_inst = ii; m_out_pc = m_pc; m_valid = 1; m_pc = m_pc + 4;
         end else begin
            m_inst = NOP; m_out_pc = 0; m_valid = 0;
         end
         if (m_stale && r) m_stale = 1'b0;
      end
   endtask

   initial begin
      drive(0, 0, 0, 0);
      // Directed sequence: zero-wait, latency, stall, drain, hold flush, wrap
      add(0,0,1,0,            1,32'h4,        32'h0,        32'h100, 1);
      add(0,0,1,0,            1,32'h8,        32'h4,        32'h104, 1);
      add(0,0,1,0,            1,32'hC,        32'h8,        32'h108, 1);
      add(0,0,0,0,            1,32'hC,        32'h0,        NOP,     0);
      add(0,0,1,0,            1,32'h10,       32'hC,        32'h10C, 1);
      add(1,0,1,0,            0,32'h14,       32'hC,        32'h10C, 1);
      add(0,0,1,0,            1,32'h14,       32'h10,       32'h110, 1);
      add(0,0,1,0,            1,32'h18,       32'h14,       32'h114, 1);
      add(0,1,0,32'h200,      0,32'h200,      32'h0,        NOP,     0);
      add(0,0,0,0,            0,32'h200,      32'h0,        NOP,     0);
      add(0,0,1,0,            1,32'h200,      32'h0,        NOP,     0);
      add(0,0,1,0,            1,32'h204,      32'h200,      32'h300, 1);
      add(1,0,1,0,            0,32'h208,      32'h200,      32'h300, 1);
      add(1,1,1,32'h40,       1,32'h40,       32'h0,        NOP,     0);
      add(0,0,1,0,            1,32'h44,       32'h40,       32'h140, 1);
      add(0,1,1,32'hFFFFFFFC, 1,32'hFFFFFFFC, 32'h0,        NOP,     0);
      add(0,0,1,0,            1,32'h0,        32'hFFFFFFFC, 32'hFC,  1);
      add(0,0,1,0,            1,32'h4,        32'h0,        32'h100, 1);
      add(1,0,0,0,            1,32'h4,        32'h0,        32'h100, 1);
      add(0,1,0,32'h80,       0,32'h80,       32'h0,        NOP,     0);
      add(0,1,1,32'h90,       1,32'h90,       32'h0,        NOP,     0);
      add(0,0,1,0,            1,32'h94,       32'h90,       32'h190, 1);

      // Reset state while rst is held
      #12;
      check_all("reset", 1'b0, 32'h0, 32'h0, NOP, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("release.req",  {31'd0, bus.imem_req_o}, 32'd1);
      chk("release.addr", bus.imem_addr_o, 32'h0);

      for (int k = 0; k < vecs.size(); k++) begin
         @(negedge clk);
         drive(vecs[k].stall, vecs[k].flush, vecs[k].ready, vecs[k].tgt);
         @(posedge clk);
         #1;
         check_all($sformatf("vec%0d", k), vecs[k].exp_req, vecs[k].exp_addr,
                   vecs[k].exp_pc, vecs[k].exp_inst, vecs[k].exp_valid);
      end

      // Reset asserted mid-wait, with a valid instruction in IF/ID
      @(negedge clk);
      drive(0, 0, 1, 0);
      @(posedge clk);
      #1;
      check_all("prerst", 1'b1, 32'h98, 32'h94, 32'h194, 1'b1);
      @(negedge clk);
      drive(0, 0, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      check_all("midrst", 1'b0, 32'h0, 32'h0, NOP, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rerelease.req",  {31'd0, bus.imem_req_o}, 32'd1);
      chk("rerelease.addr", bus.imem_addr_o, 32'h0);

      // Random traffic against the model
      m_pc = 0; m_stale = 0; m_parked = 0; m_buf_inst = 0; m_buf_pc = 0;
      m_inst = NOP; m_out_pc = 0; m_valid = 0;
      for (int n = 0; n < 600; n++) begin
         logic s, f, r;
         logic [31:0] t;
         @(negedge clk);
         s = ($urandom_range(0, 3) == 0);
         f = ($urandom_range(0, 6) == 0);
         r = ($urandom_range(0, 2) != 0);
         t = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
         drive(s, f, r, t);
         model_step(s, f, r, t, bus.imem_inst_i);
         @(posedge clk);
         #1;
         check_all($sformatf("rnd%0d", n), !m_parked && !m_stale, m_pc,
                   m_out_pc, m_inst, m_valid);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
